// File: rtl/mux2_stream_arb.sv
// Two-channel round-robin packet arbiter feeding a single registered output stage.
// A granted channel keeps ownership until its last beat is accepted.
module mux2_stream_arb #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i0_data,
    input  logic             i0_valid,
    input  logic             i0_last,
    output logic             i0_ready,
    input  logic [WIDTH-1:0] i1_data,
    input  logic             i1_valid,
    input  logic             i1_last,
    output logic             i1_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready,
    output logic             sel
);

    typedef enum logic [1:0] {
        IDLE,
        LOCK0,
        LOCK1
    } state_t;

    state_t           state_q;
    logic             prio_q;
    logic [WIDTH-1:0] outData_q;
    logic             outValid_q;
    logic             outLast_q;
    logic             sel_q;

    logic             canLoad;
    logic             grantValid;
    logic             grantCh;
    logic             grantSrcValid;
    logic             accept;
    logic [WIDTH-1:0] outData_d;
    logic             outLast_d;

    assign canLoad = ~outValid_q | out_ready;

    // IDLE arbitrates on the current valids; a locked state pins the grant even through bubbles.
    always_comb begin
        grantValid = 1'b0;
        grantCh    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i0_valid && i1_valid) begin
                    grantValid = 1'b1;
                    grantCh    = prio_q;
                end else if (i0_valid) begin
                    grantValid = 1'b1;
                    grantCh    = 1'b0;
                end else if (i1_valid) begin
                    grantValid = 1'b1;
                    grantCh    = 1'b1;
                end
            end
            LOCK0: begin
                grantValid = 1'b1;
                grantCh    = 1'b0;
            end
            LOCK1: begin
                grantValid = 1'b1;
                grantCh    = 1'b1;
            end
            default: begin
                grantValid = 1'b0;
                grantCh    = 1'b0;
            end
        endcase
    end

    assign grantSrcValid = grantCh ? i1_valid : i0_valid;
    assign accept        = grantValid & canLoad & grantSrcValid;
    assign outData_d     = grantCh ? i1_data : i0_data;
    assign outLast_d     = grantCh ? i1_last : i0_last;

    assign i0_ready = ~rst & grantValid & ~grantCh & canLoad;
    assign i1_ready = ~rst & grantValid &  grantCh & canLoad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            prio_q     <= 1'b0;
            outData_q  <= '0;
            outValid_q <= 1'b0;
            outLast_q  <= 1'b0;
            sel_q      <= 1'b0;
        end else if (accept) begin
            outData_q  <= outData_d;
            outLast_q  <= outLast_d;
            sel_q      <= grantCh;
            outValid_q <= 1'b1;
            if (outLast_d) begin
                state_q <= IDLE;
                prio_q  <= ~grantCh;
            end else begin
                state_q <= grantCh ? LOCK1 : LOCK0;
            end
        end else if (out_ready) begin
            outValid_q <= 1'b0;
        end
    end

    assign out_data  = outData_q;
    assign out_valid = outValid_q;
    assign out_last  = outLast_q;
    assign sel       = sel_q;

endmodule

// File: tb/tb_mux2_stream_arb.sv
// Directed testbench for mux2_stream_arb: reset, tie alternation, packet lock,
// backpressure, source bubble and reset mid-packet.
module tb_mux2_stream_arb;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] i0_data = '0;
    logic       i0_valid = 1'b0;
    logic       i0_last = 1'b0;
    logic       i0_ready;
    logic [7:0] i1_data = '0;
    logic       i1_valid = 1'b0;
    logic       i1_last = 1'b0;
    logic       i1_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic       out_ready = 1'b1;
    logic       sel;

    int checks = 0;
    int passed = 0;

    mux2_stream_arb #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .i0_data(i0_data), .i0_valid(i0_valid), .i0_last(i0_last), .i0_ready(i0_ready),
        .i1_data(i1_data), .i1_valid(i1_valid), .i1_last(i1_last), .i1_ready(i1_ready),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
        .out_ready(out_ready), .sel(sel)
    );

    always #5 clk = ~clk;

    // Inputs change just after a rising edge; the extra delay lets readies settle.
    task automatic applyStimulus(input logic v0, input logic [7:0] d0, input logic l0,
                                 input logic v1, input logic [7:0] d1, input logic l1,
                                 input logic ordy);
        i0_valid  = v0; i0_data = d0; i0_last = l0;
        i1_valid  = v1; i1_data = d1; i1_last = l1;
        out_ready = ordy;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        applyStimulus(1'b1, 8'h55, 1'b1, 1'b1, 8'h66, 1'b1, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || sel !== 1'b0)
            $display("[TB] FAIL reset_out got valid=%b sel=%b expected 0/0", out_valid, sel);
        else passed++;
        checks++;
        if (i0_ready !== 1'b0 || i1_ready !== 1'b0)
            $display("[TB] FAIL reset_ready got %b%b expected 00", i0_ready, i1_ready);
        else passed++;
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (i0_ready !== 1'b1 || i1_ready !== 1'b0)
            $display("[TB] FAIL reset_first_grant got %b%b expected 10", i0_ready, i1_ready);
        else passed++;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h55 || sel !== 1'b0)
            $display("[TB] FAIL reset_first_beat got v=%b d=%h s=%b expected 1/55/0",
                     out_valid, out_data, sel);
        else passed++;
    endtask

    task automatic test_tie_alternation();
        logic [7:0] expData;
        doReset();
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b1, 8'hA0 + 8'(k / 2), 1'b1, 1'b1, 8'hB0 + 8'(k / 2), 1'b1, 1'b1);
            step();
            expData = (k % 2 == 0) ? 8'hA0 + 8'(k / 2) : 8'hB0 + 8'(k / 2);
            checks++;
            if (out_valid !== 1'b1 || out_data !== expData || sel !== 1'(k % 2))
                $display("[TB] FAIL tie_%0d got v=%b d=%h s=%b expected 1/%h/%0d",
                         k, out_valid, out_data, sel, expData, k % 2);
            else passed++;
        end
    endtask

    task automatic test_packet_lock();
        logic [7:0] beats [3];
        beats[0] = 8'h11; beats[1] = 8'h12; beats[2] = 8'h13;
        doReset();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, beats[k], 1'(k == 2), 1'b1, 8'h21, 1'b1, 1'b1);
            checks++;
            if (i1_ready !== 1'b0)
                $display("[TB] FAIL lock_block_%0d got i1_ready=%b expected 0", k, i1_ready);
            else passed++;
            step();
            checks++;
            if (out_data !== beats[k] || sel !== 1'b0 || out_last !== 1'(k == 2))
                $display("[TB] FAIL lock_beat_%0d got d=%h s=%b l=%b expected %h/0/%0d",
                         k, out_data, sel, out_last, beats[k], k == 2);
            else passed++;
        end
        applyStimulus(1'b1, 8'h14, 1'b1, 1'b1, 8'h21, 1'b1, 1'b1);
        step();
        checks++;
        if (out_data !== 8'h21 || sel !== 1'b1 || out_valid !== 1'b1)
            $display("[TB] FAIL lock_switch got d=%h s=%b v=%b expected 21/1/1",
                     out_data, sel, out_valid);
        else passed++;
    endtask

    task automatic test_backpressure();
        logic [7:0] rest [3];
        rest[0] = 8'h32; rest[1] = 8'h33; rest[2] = 8'h34;
        doReset();
        applyStimulus(1'b1, 8'h31, 1'b0, 1'b1, 8'h41, 1'b1, 1'b1);
        step();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 8'h32, 1'b0, 1'b1, 8'h41, 1'b1, 1'b0);
            checks++;
            if (i0_ready !== 1'b0 || i1_ready !== 1'b0)
                $display("[TB] FAIL bp_ready_%0d got %b%b expected 00", k, i0_ready, i1_ready);
            else passed++;
            step();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h31 || out_last !== 1'b0 || sel !== 1'b0)
                $display("[TB] FAIL bp_hold_%0d got v=%b d=%h l=%b s=%b expected 1/31/0/0",
                         k, out_valid, out_data, out_last, sel);
            else passed++;
        end
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, rest[k], 1'(k == 2), 1'b1, 8'h41, 1'b1, 1'b1);
            step();
            checks++;
            if (out_valid !== 1'b1 || out_data !== rest[k] || sel !== 1'b0)
                $display("[TB] FAIL bp_release_%0d got v=%b d=%h s=%b expected 1/%h/0",
                         k, out_valid, out_data, sel, rest[k]);
            else passed++;
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 8'h41, 1'b1, 1'b1);
        step();
        checks++;
        if (out_data !== 8'h41 || sel !== 1'b1 || out_last !== 1'b1)
            $display("[TB] FAIL bp_next got d=%h s=%b l=%b expected 41/1/1", out_data, sel, out_last);
        else passed++;
    endtask

    task automatic test_source_bubble();
        doReset();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 8'h51, 1'b0, 1'b1);
        step();
        checks++;
        if (out_data !== 8'h51 || sel !== 1'b1)
            $display("[TB] FAIL bubble_first got d=%h s=%b expected 51/1", out_data, sel);
        else passed++;
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b1, 8'h61, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
            checks++;
            if (i0_ready !== 1'b0)
                $display("[TB] FAIL bubble_block_%0d got i0_ready=%b expected 0", k, i0_ready);
            else passed++;
            step();
            checks++;
            if (out_valid !== 1'b0)
                $display("[TB] FAIL bubble_empty_%0d got out_valid=%b expected 0", k, out_valid);
            else passed++;
        end
        applyStimulus(1'b1, 8'h61, 1'b1, 1'b1, 8'h52, 1'b1, 1'b1);
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h52 || sel !== 1'b1 || out_last !== 1'b1)
            $display("[TB] FAIL bubble_finish got v=%b d=%h s=%b l=%b expected 1/52/1/1",
                     out_valid, out_data, sel, out_last);
        else passed++;
        applyStimulus(1'b1, 8'h61, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        step();
        checks++;
        if (out_data !== 8'h61 || sel !== 1'b0)
            $display("[TB] FAIL bubble_ch0 got d=%h s=%b expected 61/0", out_data, sel);
        else passed++;
    endtask

    task automatic test_reset_mid_packet();
        doReset();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 8'h71, 1'b0, 1'b1);
        step();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 8'h72, 1'b0, 1'b1);
        step();
        checks++;
        if (out_data !== 8'h72 || sel !== 1'b1)
            $display("[TB] FAIL midrst_beat2 got d=%h s=%b expected 72/1", out_data, sel);
        else passed++;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || sel !== 1'b0)
            $display("[TB] FAIL midrst_clear got v=%b d=%h s=%b expected 0/00/0",
                     out_valid, out_data, sel);
        else passed++;
        step();
        rst = 1'b0;
        applyStimulus(1'b1, 8'h81, 1'b1, 1'b1, 8'h73, 1'b0, 1'b1);
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h81 || sel !== 1'b0)
            $display("[TB] FAIL midrst_after got v=%b d=%h s=%b expected 1/81/0",
                     out_valid, out_data, sel);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_tie_alternation();
        test_packet_lock();
        test_backpressure();
        test_source_bubble();
        test_reset_mid_packet();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/mux2_stream_arb.md
# mux2_stream_arb

Two-channel round-robin packet arbiter that sits directly upstream of the 2:1 data mux path. It accepts two valid/ready streams and selects one whole packet at a time, up to and including the beat with `last`. The selected beats are forwarded through a single registered output stage. The output `sel` tells downstream consumers which channel the current output beat came from.

## Interface
Parameters:
- `WIDTH`, 8, data width of each channel and of the output.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `i0_data`  in  WIDTH  channel 0 data.
- `i0_valid`  in  1  channel 0 beat valid.
- `i0_last`  in  1  channel 0 final beat of packet.
- `i0_ready`  out  1  channel 0 beat accepted when `i0_valid & i0_ready`.
- `i1_data`, `i1_valid`, `i1_last`, `i1_ready`: same as channel 0, for channel 1.
- `out_data`  out  WIDTH  registered output data.
- `out_valid`  out  1  output beat valid.
- `out_last`  out  1  output beat ends packet.
- `out_ready`  in  1  downstream accepts when `out_valid & out_ready`.
- `sel`  out  1  source channel of the beat in the output register.

## Operation
- FSM states:
  - IDLE: no packet owned.
  - LOCK0: channel 0 owns the output mid-packet.
  - LOCK1: channel 1 owns the output mid-packet.
- Priority pointer `prio`, 1 bit, reset 0. `prio` names the channel that wins a tie.
- Output register free this cycle: `can_load = ~out_valid | out_ready`.
- Grant rules:
  - IDLE: grant goes to `prio` if both channels are valid, otherwise to whichever channel is valid. No grant if neither is valid.
  - LOCKx: grant is always channel x.
- Ready: `iN_ready = grant_is_N & can_load`. The non-granted channel's ready is 0.
- On an accepted beat from channel N:
  - Load the output register: `out_data <= iN_data`, `out_last <= iN_last`, `sel <= N`, `out_valid <= 1`.
  - If `iN_last=1`: go to IDLE and set `prio <= ~N`.
  - Otherwise: go to (or stay in) LOCKN.
- A single-beat packet accepted in IDLE leaves the FSM in IDLE. `prio` still flips.
- In LOCKx with `ix_valid=0` (source bubble): the grant is held and the other channel stays blocked.
- No load and `out_ready=1`: `out_valid <= 0`. `out_data`, `out_last` and `sel` hold their last values.
- Under backpressure (`out_valid=1`, `out_ready=0`), the output register holds stable and both readies are 0.

## Timing
- Reset values (asynchronous, immediate):
  - `out_valid=0`, `out_last=0`, `out_data=0`, `sel=0`.
  - `prio=0`, state IDLE.
  - `i0_ready=i1_ready=0` while `rst=1`.
- Latency: an input beat accepted at edge k appears on `out_*` immediately after edge k.
- Throughput: 1 beat/cycle sustained while `out_ready=1`, including back-to-back packets from alternating channels.
- Arbitration in IDLE is combinational on the current cycle's valids. There is no dead cycle between packets.
- A channel switch takes effect only after the `last` beat is accepted. A packet is never interleaved with the other channel.
- Simultaneous `last` accept and new `valid` on the other channel: the other channel wins on the next cycle, because `prio` already points to it.
- Reset asserted mid-packet: the partial packet is discarded, the output is cleared, and the FSM returns to IDLE with `prio=0`. After reset the sources are responsible for restarting their packets.
- Ready does not depend combinationally on the inputs' `valid` for the locked channel. In IDLE, ready depends on both valids.

## Test plan
- Reset check: assert `rst` with both channels valid. Required: `out_valid=0`, `sel=0`, `i0_ready=i1_ready=0`. Release reset with `out_ready=1` and both valid, `last=1`. Required: channel 0 is granted first, so `out_data=i0_data`, `sel=0`.
- Tie alternation: both channels present continuous single-beat packets (ch0 data 0xA0.., ch1 data 0xB0..) with `out_ready=1`. Required: output sequence A0, B0, A1, B1, … and `sel` toggles every cycle.
- Packet lock: ch0 sends a 3-beat packet (0x11, 0x12, 0x13 with `last` on 0x13) while ch1 is valid throughout. Required: 0x11–0x13 appear consecutively with `sel=0` and `i1_ready=0` throughout. Ch1's beat appears on the next cycle with `sel=1`.
- Backpressure: hold `out_ready=0` for 4 cycles mid-packet. Required: `out_data`, `out_last` and `sel` stay stable, both readies stay 0, and no beat is lost or duplicated after release.
- Source bubble: ch1 drops `valid` for 2 cycles mid-packet while ch0 is valid. Required: ch0 stays blocked and ch1 completes its packet before ch0 is granted.
- Reset mid-packet: assert `rst` after beat 2 of a 4-beat ch1 packet. Required: `out_valid` goes 0 immediately. On the first cycle after release with both channels valid, `sel=0` (ch0 granted).
